// File: rtl/hazard_controller_pkg.sv
// Shared pipeline widths and hazard-controller FSM encodings.
package hazard_controller_pkg;

  localparam int unsigned REG_IDX_WIDTH = 5;
  localparam int unsigned WORD_LEN      = 32;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_HUNG     = 2'd2
  } hz_state_e;

  // A register operand matches a destination only if it is used and is not x0.
  function automatic logic reg_match(input logic                     used,
                                     input logic [REG_IDX_WIDTH-1:0] src,
                                     input logic [REG_IDX_WIDTH-1:0] dst);
    return used && (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use/branch interlocks, ID redirects,
// data-memory wait freeze with hang detection, and stall/flush counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [REG_IDX_WIDTH-1:0] readAddr1_ID,
  input  logic [REG_IDX_WIDTH-1:0] readAddr2_ID,
  input  logic                     usesRs1_ID,
  input  logic                     usesRs2_ID,
  input  logic                     isBranch_ID,
  input  logic                     redirect_ID,
  input  logic                     regWrite_EX,
  input  logic                     memRead_EX,
  input  logic [REG_IDX_WIDTH-1:0] writeAddr_EX,
  input  logic                     regWrite_MEM,
  input  logic                     memRead_MEM,
  input  logic [REG_IDX_WIDTH-1:0] writeAddr_MEM,
  input  logic                     memReq_MEM,
  input  logic                     memReady,
  output logic                     stall_IF,
  output logic                     stall_ID,
  output logic                     stall_EX,
  output logic                     stall_MEM,
  output logic                     bubble_EX,
  output logic                     flush_ID,
  output logic                     memError,
  output logic [CNT_WIDTH-1:0]     stallCount,
  output logic [CNT_WIDTH-1:0]     flushCount
);

  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);

  hz_state_e      r_state, w_next_state;
  logic [WCW-1:0] r_waitCnt, w_next_waitCnt;

  logic w_hazMatch_EX, w_hazMatch_MEM, w_loadUse, w_branchHaz;
  logic w_memWait, w_freeze, w_dataStall, w_redirect;

  assign w_hazMatch_EX  = regWrite_EX &&
                          (reg_match(usesRs1_ID, readAddr1_ID, writeAddr_EX) ||
                           reg_match(usesRs2_ID, readAddr2_ID, writeAddr_EX));
  assign w_hazMatch_MEM = regWrite_MEM &&
                          (reg_match(usesRs1_ID, readAddr1_ID, writeAddr_MEM) ||
                           reg_match(usesRs2_ID, readAddr2_ID, writeAddr_MEM));
  assign w_loadUse      = memRead_EX && w_hazMatch_EX;
  // ALU results in MEM are forwarded to ID, so only a load there blocks a branch.
  assign w_branchHaz    = isBranch_ID && (w_hazMatch_EX || (memRead_MEM && w_hazMatch_MEM));
  assign w_memWait      = memReq_MEM && !memReady;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= HZ_RUN;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_waitCnt <= w_next_waitCnt;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_waitCnt = r_waitCnt;
    w_freeze       = 1'b0;
    w_dataStall    = 1'b0;
    w_redirect     = 1'b0;
    stall_IF       = 1'b0;
    stall_ID       = 1'b0;
    stall_EX       = 1'b0;
    stall_MEM      = 1'b0;
    bubble_EX      = 1'b0;
    flush_ID       = 1'b0;
    memError       = 1'b0;

    case (r_state)
      HZ_RUN: begin
        if (w_memWait) begin
          w_next_state   = HZ_MEM_WAIT;
          w_next_waitCnt = WCW'(1);
        end
      end
      HZ_MEM_WAIT: begin
        if (memReady) begin
          w_next_state = HZ_RUN;
        end else begin
          w_next_waitCnt = r_waitCnt + 1'b1;
          if (w_next_waitCnt == TIMEOUT_V) begin
            w_next_state = HZ_HUNG;
          end
        end
      end
      HZ_HUNG: memError = 1'b1;
      default: w_next_state = HZ_RUN;
    endcase

    // Interlocks and redirects are masked while in reset; a memory wait still freezes.
    w_freeze    = w_memWait || (r_state == HZ_HUNG);
    w_dataStall = (w_loadUse || w_branchHaz) && !w_freeze && rstn;
    w_redirect  = redirect_ID && !w_freeze && !w_dataStall && rstn;

    stall_IF  = w_freeze || w_dataStall;
    stall_ID  = w_freeze || w_dataStall;
    stall_EX  = w_freeze;
    stall_MEM = w_freeze;
    bubble_EX = w_dataStall;
    flush_ID  = w_redirect;
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (stall_IF),
    .count (stallCount)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (flush_ID),
    .count (flushCount)
  );

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, is the number of consecutive data-memory wait cycles before the pipeline is declared hung.
REQ-002 Parameter CNT_WIDTH, default 32, is the width of the stall and flush performance counters.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk  in  1  rising-edge clock.
REQ-005 Port rstn  in  1  asynchronous active-low reset.
REQ-006 Ports readAddr1_ID, readAddr2_ID  in  REG_IDX_WIDTH  source registers of the ID instruction.
REQ-007 Ports usesRs1_ID, usesRs2_ID, isBranch_ID, redirect_ID  in  1  operand-use flags, branch/jump in ID, taken redirect resolved in ID.
REQ-008 Ports regWrite_EX, memRead_EX  in  1; writeAddr_EX  in  REG_IDX_WIDTH  destination of the EX instruction.
REQ-009 Ports regWrite_MEM, memRead_MEM  in  1; writeAddr_MEM  in  REG_IDX_WIDTH  destination of the MEM instruction.
REQ-010 Ports memReq_MEM, memReady  in  1  data-memory access in MEM and its completion.
REQ-011 Ports stall_IF, stall_ID, stall_EX, stall_MEM  out  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-012 Ports bubble_EX, flush_ID  out  1  load a NOP into ID/EX and into IF/ID.
REQ-013 Port memError  out  1  sticky hang indication; stallCount, flushCount  out  CNT_WIDTH  performance counters.

Function
REQ-014 Match(x,a,b) SHALL be defined as (a != 0) and (a == b), with the use flag ANDed per operand: hazMatch_EX = regWrite_EX and Match over used rs1/rs2 against writeAddr_EX; hazMatch_MEM likewise against writeAddr_MEM.
REQ-015 loadUse SHALL be memRead_EX and hazMatch_EX.
REQ-016 branchHaz SHALL be isBranch_ID and (hazMatch_EX or (memRead_MEM and hazMatch_MEM)); an ALU result in MEM is forwarded to ID and raises no hazard.
REQ-017 memWait SHALL be memReq_MEM and not memReady.
REQ-018 FSM states SHALL be RUN, MEM_WAIT and HUNG; the reset state is RUN.
REQ-019 In RUN with memWait, the FSM SHALL go to MEM_WAIT and load waitCnt = 1; otherwise it stays in RUN.
REQ-020 In MEM_WAIT, memReady SHALL cause a return to RUN; otherwise waitCnt increments, and when waitCnt == MEM_TIMEOUT the FSM goes to HUNG.
REQ-021 HUNG SHALL persist until reset, with memError = 1.
REQ-022 Outputs SHALL be combinational from state and inputs in the same cycle, with priority freeze > dataStall > redirect.
REQ-023 freeze = memWait or state == HUNG: all four stall outputs = 1, with bubble_EX = 0 and flush_ID = 0.
REQ-024 dataStall = (loadUse or branchHaz) and not freeze: stall_IF = stall_ID = 1 and bubble_EX = 1; stall_EX, stall_MEM and flush_ID = 0, so the redirect is ignored because its operands are stale.
REQ-025 A load in EX feeding a branch in ID SHALL stall 2 cycles: cycle 1 via hazMatch_EX, cycle 2 via memRead_MEM and hazMatch_MEM.
REQ-026 Redirect without freeze or dataStall SHALL produce flush_ID = 1 for that cycle only, with no stalls.
REQ-027 A redirect held in ID during a freeze SHALL take effect in the first unfrozen cycle.
REQ-028 stallCount SHALL increment each cycle stall_IF = 1 and flushCount each cycle flush_ID = 1, both saturating at all-ones.

Reset
REQ-029 On rstn low, asynchronously: state = RUN, waitCnt = 0, memError = 0, stallCount = flushCount = 0.
REQ-030 Combinational outputs SHALL be 0 during reset except where memWait forces a freeze.
REQ-031 Reset asserted in MEM_WAIT or HUNG SHALL return the FSM to RUN on the next edge after release, with no residual stall.

Structure
REQ-032 REG_IDX_WIDTH and WORD_LEN SHALL come from the shared defines; FSM state encodings (2 bits) SHALL be added there as HZ_RUN, HZ_MEM_WAIT and HZ_HUNG.
REQ-033 One sub-module, sat_counter (parameter WIDTH, inputs inc and rstn), SHALL implement both performance counters.

Verification
REQ-034 Load-use: lw x5 in EX, add using x5 in ID -> 1 cycle of stall_IF/stall_ID/bubble_EX = 1, stallCount = 1.
REQ-035 Load-branch: lw x6 then beq x6 -> exactly 2 stall cycles; beq after add x6 -> 1 stall cycle; rd = x0 -> 0 stall cycles.
REQ-036 Redirect: redirect_ID = 1 with no hazard -> flush_ID = 1 for 1 cycle, flushCount = 1; with loadUse in the same cycle -> flush_ID = 0 and bubble_EX = 1.
REQ-037 Memory wait: memReq_MEM = 1 with memReady low for 3 cycles -> all stalls = 1 for 3 cycles, then RUN; a concurrent loadUse asserts no bubble_EX during the wait.
REQ-038 Timeout: MEM_TIMEOUT = 4 with memReady held low -> HUNG after the 4th wait cycle, memError = 1 and sticky; rstn pulse -> RUN and memError = 0.
REQ-039 Saturation: CNT_WIDTH = 4 with 20 stall cycles -> stallCount = 15.
